lcd_host_arbiter: RTL and testbench



---
 rtl/lcd_host_arbiter.sv | 143 ++++++++++++++
 tb/tb_lcd_host_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_host_arbiter.sv
// Purpose: round-robin arbiter sharing one LCD_Controller host port between two
//          requesters of 9-bit words {RS, DATA}; drives iStart/oDone and the settling gap.
// Latency: start one cycle after request; ack (gap+1) cycles after controller done.
// Backpressure: requests are level-held until their one-cycle ack; one holdoff cycle follows every ack.
// Ports: iCLK/iRST_N (async active-low); iREQx/iWORDx/oACKx per requester;
//        oLCD_DATA/oLCD_RS/oLCD_START/iLCD_DONE to the controller; oBUSY, oOWNER status.
// Option: define LCD_LONG_DLY_EN to give clear/home commands (RS=0, data 01..03) the LONG_DLY gap.
module lcd_host_arbiter #(
    parameter int CMD_DLY  = 262142,
    parameter int LONG_DLY = 2000000,
    parameter int CNT_W    = 21
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iREQ0,
    input  logic [8:0] iWORD0,
    output logic       oACK0,
    input  logic       iREQ1,
    input  logic [8:0] iWORD1,
    output logic       oACK1,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_START,
    input  logic       iLCD_DONE,
    output logic       oBUSY,
    output logic       oOWNER
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_DLY);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, last_nxt;       // round-robin pointer: last requester served
    logic [7:0]       data_nxt;
    logic             rs_nxt, start_nxt, owner_nxt, ack0_nxt, ack1_nxt;
    logic             winner;
    logic [8:0]       sel_word;
    logic [CNT_W-1:0] gap_last;

`ifdef LCD_LONG_DLY_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DLY);
    logic long_sel, long_nxt, sel_is_long;

    // Clear (01) and home (02/03) commands need the controller's long execution time.
    assign sel_is_long = !sel_word[8] && (sel_word[7:0] >= 8'h01) && (sel_word[7:0] <= 8'h03);
    assign gap_last    = long_sel ? LONG_LAST : CMD_LAST;
`else
    assign gap_last    = CMD_LAST;
`endif

    // Contention goes to the requester not served last; a lone requester always wins.
    assign winner   = iREQ0 ? (iREQ1 ? ~last : 1'b0) : 1'b1;
    assign sel_word = winner ? iWORD1 : iWORD0;
    assign oBUSY    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        data_nxt  = oLCD_DATA;
        rs_nxt    = oLCD_RS;
        start_nxt = oLCD_START;
        owner_nxt = oOWNER;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
`ifdef LCD_LONG_DLY_EN
        long_nxt  = long_sel;
`endif
        case (state)
            IDLE: begin
                // The cycle an ack is visible is a holdoff so the requester can drop its level.
                if (!oACK0 && !oACK1 && (iREQ0 || iREQ1)) begin
                    owner_nxt = winner;
                    last_nxt  = winner;
                    data_nxt  = sel_word[7:0];
                    rs_nxt    = sel_word[8];
                    start_nxt = 1'b1;
`ifdef LCD_LONG_DLY_EN
                    long_nxt  = sel_is_long;
`endif
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iLCD_DONE) begin
                    start_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // Counter reaches gap after gap full cycles; the ack lands one edge later,
                // giving gap+1 cycles from done to ack.
                if (cnt == gap_last) begin
                    ack0_nxt  = ~oOWNER;
                    ack1_nxt  = oOWNER;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            oLCD_DATA  <= 8'h00;
            oLCD_RS    <= 1'b0;
            oLCD_START <= 1'b0;
            oOWNER     <= 1'b0;
            oACK0      <= 1'b0;
            oACK1      <= 1'b0;
`ifdef LCD_LONG_DLY_EN
            long_sel   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            oLCD_DATA  <= data_nxt;
            oLCD_RS    <= rs_nxt;
            oLCD_START <= start_nxt;
            oOWNER     <= owner_nxt;
            oACK0      <= ack0_nxt;
            oACK1      <= ack1_nxt;
`ifdef LCD_LONG_DLY_EN
            long_sel   <= long_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_host_arbiter.sv
// Purpose: randomized self-checking bench for lcd_host_arbiter against a transaction-level model.
// Ports: none (top-level bench); drives requesters and plays the LCD controller done handshake.
module tb_lcd_host_arbiter;

    localparam int CMD_DLY  = 4;
    localparam int LONG_DLY = 10;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       iREQ0, iREQ1, iLCD_DONE;
    logic [8:0] iWORD0, iWORD1;
    logic       oACK0, oACK1, oLCD_RS, oLCD_START, oBUSY, oOWNER;
    logic [7:0] oLCD_DATA;

    int checks = 0;
    int errors = 0;

    // Model state: pending request level and word per requester, and who was served last.
    logic       pend [2];
    logic [8:0] word [2];
    int         last_m;

    lcd_host_arbiter #(.CMD_DLY(CMD_DLY), .LONG_DLY(LONG_DLY), .CNT_W(21)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iREQ0(iREQ0), .iWORD0(iWORD0), .oACK0(oACK0),
        .iREQ1(iREQ1), .iWORD1(iWORD1), .oACK1(oACK1),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_START(oLCD_START),
        .iLCD_DONE(iLCD_DONE), .oBUSY(oBUSY), .oOWNER(oOWNER)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive();
        iREQ0  = pend[0];
        iWORD0 = word[0];
        iREQ1  = pend[1];
        iWORD1 = word[1];
    endtask

    function automatic logic [8:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 9'h001;
            1:       return 9'h002;
            2:       return 9'h003;
            3:       return 9'h101;
            default: return 9'($urandom);
        endcase
    endfunction

    function automatic int exp_gap(input logic [8:0] w);
`ifdef LCD_LONG_DLY_EN
        if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03))
            return LONG_DLY;
`endif
        return CMD_DLY;
    endfunction

    // Requests are already driven; the next edge must grant. Runs the transfer
    // through its ack and the following holdoff cycle.
    task automatic run_txn();
        int         w;
        logic [8:0] ew;
        int         g;
        w  = pend[0] ? (pend[1] ? (last_m == 1 ? 0 : 1) : 0) : 1;
        ew = word[w];
        last_m = w;
        g  = exp_gap(ew);

        step();
        chk("grant_start", oLCD_START, 1);
        chk("grant_data",  oLCD_DATA, ew[7:0]);
        chk("grant_rs",    oLCD_RS, ew[8]);
        chk("grant_owner", oOWNER, w);
        chk("grant_busy",  oBUSY, 1);

        // The winner may drop its request or scribble its word; the transfer must not care.
        if ($urandom_range(0, 2) == 0) pend[w] = 1'b0;
        if ($urandom_range(0, 2) == 0) word[w] = rand_word();
        drive();

        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            step();
            chk("wait_start", oLCD_START, 1);
            chk("wait_data",  {oLCD_RS, oLCD_DATA}, ew);
        end

        iLCD_DONE = 1'b1;
        step();
        iLCD_DONE = 1'b0;
        chk("done_start", oLCD_START, 0);
        chk("done_busy",  oBUSY, 1);

        for (int i = 1; i <= g; i++) begin
            iLCD_DONE = 1'($urandom_range(0, 1));
            step();
            chk("gap_noack", {oACK1, oACK0}, 0);
        end
        iLCD_DONE = 1'b0;
        step();
        chk("ack", {oACK1, oACK0}, (w == 1) ? 2 : 1);
        chk("ack_idle", oBUSY, 0);
        chk("ack_data", {oLCD_RS, oLCD_DATA}, ew);

        // Owner re-rolls its request; the other side keeps its pending one.
        pend[w] = 1'($urandom_range(0, 1));
        word[w] = rand_word();
        drive();
        step();
        chk("holdoff_ack",   {oACK1, oACK0}, 0);
        chk("holdoff_start", oLCD_START, 0);
        chk("holdoff_busy",  oBUSY, 0);
    endtask

    initial begin
        iRST_N    = 1'b0;
        iLCD_DONE = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        word[0] = 9'h000; word[1] = 9'h000;
        last_m  = 1;
        drive();
        step();
        step();
        chk("rst_outputs", {oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_START, oBUSY, oOWNER}, 0);
        iRST_N = 1'b1;
        step();

        // Done pulse while idle with nothing requested must be ignored.
        iLCD_DONE = 1'b1;
        step();
        step();
        iLCD_DONE = 1'b0;
        chk("idle_done_busy", oBUSY, 0);
        chk("idle_done_ack",  {oACK1, oACK0}, 0);
        chk("idle_done_start", oLCD_START, 0);

        // First contention: both requesters rise together, requester 0 must win.
        pend[0] = 1'b1; word[0] = 9'h141;
        pend[1] = 1'b1; word[1] = 9'h142;
        drive();

        for (int n = 0; n < 40; n++) begin
            if (!pend[0] && !pend[1]) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    iLCD_DONE = 1'($urandom_range(0, 1));
                    step();
                    chk("idle_busy", oBUSY, 0);
                    chk("idle_ack",  {oACK1, oACK0}, 0);
                end
                iLCD_DONE = 1'b0;
                case ($urandom_range(0, 2))
                    0:       pend[0] = 1'b1;
                    1:       pend[1] = 1'b1;
                    default: begin pend[0] = 1'b1; pend[1] = 1'b1; end
                endcase
                drive();
            end
            run_txn();
        end

        // Reset mid-transfer: outputs clear immediately, no ack, pointer back to "1 last".
        pend[0] = 1'b0; pend[1] = 1'b1; word[1] = 9'h038;
        drive();
        step();
        chk("pre_rst_start", oLCD_START, 1);
        #2 iRST_N = 1'b0;
        #1;
        chk("async_rst_start", oLCD_START, 0);
        chk("async_rst_busy",  oBUSY, 0);
        chk("async_rst_acks",  {oACK1, oACK0}, 0);
        chk("async_rst_owner", oOWNER, 0);
        pend[0] = 1'b1; word[0] = 9'h120;
        pend[1] = 1'b1; word[1] = 9'h121;
        drive();
        step();
        iRST_N = 1'b1;
        step();
        chk("post_rst_owner", oOWNER, 0);
        chk("post_rst_data",  {oLCD_RS, oLCD_DATA}, 9'h120);
        chk("post_rst_start", oLCD_START, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
